// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end: idle command value, key
// codes, keypad scanner state encoding and small scanner helper functions.
// No ports (package).
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam logic [3:0] IDLE_CMD     = 4'hF;

    // Key codes are {row[1:0], col[1:0]} of the physical keypad.
    localparam logic [3:0] KEY_0        = 4'h0;
    localparam logic [3:0] KEY_1        = 4'h1;
    localparam logic [3:0] KEY_2        = 4'h2;
    localparam logic [3:0] KEY_3        = 4'h3;
    localparam logic [3:0] KEY_4        = 4'h4;
    localparam logic [3:0] KEY_5        = 4'h5;
    localparam logic [3:0] KEY_6        = 4'h6;
    localparam logic [3:0] KEY_7        = 4'h7;
    localparam logic [3:0] KEY_8        = 4'h8;
    localparam logic [3:0] KEY_9        = 4'h9;
    localparam logic [3:0] KEY_ADD      = 4'hA;
    localparam logic [3:0] KEY_SUB      = 4'hB;
    localparam logic [3:0] KEY_MUL      = 4'hC;
    localparam logic [3:0] KEY_EQ       = 4'hD;
    localparam logic [3:0] KEY_CLR      = 4'hE;
    // Row 3 / column 3: debounced and held like any key but never reported.
    localparam logic [3:0] KEY_UNMAPPED = 4'hF;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } scan_state_t;

    // Active-low column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    // Index of the lowest-numbered low (pressed) row.
    function automatic logic [1:0] lowest_low(input logic [3:0] rs);
        if (!rs[0])      return 2'd0;
        else if (!rs[1]) return 2'd1;
        else if (!rs[2]) return 2'd2;
        else             return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser, parameterised width, async active-high reset to
// all-ones (matches an idle, pulled-up keypad row bus).
// Ports:
//   i_clock  - clock
//   i_reset  - asynchronous active-high reset
//   i_d      - asynchronous input bus
//   o_q      - synchronised output bus
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces press and release, and
// emits one 4-bit command strobe per accepted press.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat while a key is held
// (REPEAT_DELAY cycles to the first repeat, then every REPEAT_PERIOD).
// Ports:
//   clock      - system clock
//   reset      - asynchronous active-high reset
//   rows_in    - keypad rows, active-low, asynchronous
//   cols_out   - column drive, exactly one bit low
//   cmd        - key code while cmd_valid, else IDLE_CMD
//   cmd_valid  - one-cycle strobe per accepted press (and repeat)
//   key_held   - high while an accepted key is down
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int          SCAN_DIV        = 1000,  // >= 4
    parameter int          DEBOUNCE_CYCLES = 20000, // >= 2
    parameter logic [3:0]  IDLE_CMD        = calc_pkg::IDLE_CMD
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int          REPEAT_DELAY    = 25_000_000,
    parameter int          REPEAT_PERIOD   = 5_000_000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows_in,
    output logic [3:0] cols_out,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       key_held
);
    import calc_pkg::*;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_col;
    logic [1:0]       r_row;

    logic [3:0]       w_rs;
    logic [1:0]       w_col_next;
    logic [3:0]       w_code;
    logic             w_row_up;

    sync2 #(.WIDTH(4)) u_rows_sync (
        .i_clock (clock),
        .i_reset (reset),
        .i_d     (rows_in),
        .o_q     (w_rs)
    );

    assign w_col_next = r_col + 2'd1;
    assign w_code     = {r_row, r_col};
    assign w_row_up   = w_rs[r_row];  // latched row released (or bounced)

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX);

    logic [REP_W-1:0] r_rep;
    logic             r_rep_phase;  // 0: waiting for first repeat, 1: periodic
    logic [REP_W-1:0] w_rep_last;

    assign w_rep_last = r_rep_phase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= SCAN;
            r_div     <= '0;
            r_cnt     <= '0;
            r_col     <= 2'd0;
            r_row     <= 2'd0;
            cols_out  <= 4'b1110;
            cmd       <= IDLE_CMD;
            cmd_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= '0;
            r_rep_phase <= 1'b0;
`endif
        end else begin
            // Strobes last one cycle; cmd falls back to idle with them.
            cmd_valid <= 1'b0;
            cmd       <= IDLE_CMD;
            case (r_state)
                SCAN: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (w_rs == 4'hF) begin
                            r_col    <= w_col_next;
                            cols_out <= col_drive(w_col_next);
                        end else begin
                            r_row   <= lowest_low(w_rs);
                            r_cnt   <= '0;
                            r_state <= DEBOUNCE;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (w_row_up) begin
                        r_state  <= SCAN;
                        r_div    <= '0;
                        r_col    <= w_col_next;
                        cols_out <= col_drive(w_col_next);
                    end else if (r_cnt == CNT_LAST) begin
                        r_state  <= EMIT;
                        key_held <= 1'b1;
                        if (w_code != KEY_UNMAPPED) begin
                            cmd_valid <= 1'b1;
                            cmd       <= w_code;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                EMIT: begin
                    r_state <= HOLD;
                    r_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
                    // Counts cycles since the initial strobe.
                    r_rep       <= REP_W'(1);
                    r_rep_phase <= 1'b0;
`endif
                end
                HOLD: begin
                    if (w_row_up) begin
`ifdef KEYPAD_REPEAT_EN
                        r_rep       <= '0;
                        r_rep_phase <= 1'b0;
`endif
                        if (r_cnt == CNT_LAST) begin
                            r_state  <= SCAN;
                            r_div    <= '0;
                            key_held <= 1'b0;
                            r_col    <= w_col_next;
                            cols_out <= col_drive(w_col_next);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                        if (r_rep == w_rep_last) begin
                            r_rep       <= '0;
                            r_rep_phase <= 1'b1;
                            if (w_code != KEY_UNMAPPED) begin
                                cmd_valid <= 1'b1;
                                cmd       <= w_code;
                            end
                        end else begin
                            r_rep <= r_rep + REP_W'(1);
                        end
`endif
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A keypad model pulls row r low whenever pressed[r][c] is set and column c
// is driven low. All timing below is counted in clock edges from a known
// scanner phase.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows_in;
    logic [3:0] cols_out;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       key_held;

    logic [3:0][3:0] pressed = '0;  // [row][col]

    int n_pass  = 0;
    int n_total = 0;
    int pulses  = 0;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .IDLE_CMD        (4'hF)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (10)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rows_in   (rows_in),
        .cols_out  (cols_out),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    always_comb begin
        rows_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (|(pressed[r] & ~cols_out)) rows_in[r] = 1'b0;
    end

    always @(negedge clock) if (cmd_valid === 1'b1) pulses = pulses + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_out(input string tag);
        check({tag, "_cmd"}, 32'(cmd), 32'hF);
        check({tag, "_vld"}, 32'(cmd_valid), 32'h0);
    endtask

    initial begin
        // ---- reset state
        tick(3);
        reset = 1'b0;
        check("rst_cols", 32'(cols_out), 32'hE);
        check_idle_out("rst");
        check("rst_held", 32'(key_held), 32'h0);

        // ---- idle column rotation
        tick(4); check("idle_c1", 32'(cols_out), 32'hD);
        tick(4); check("idle_c2", 32'(cols_out), 32'hB);
        tick(4); check("idle_c3", 32'(cols_out), 32'h7);
        tick(4); check("idle_c0", 32'(cols_out), 32'hE);
        check_idle_out("idle");
        check("idle_pulses", 32'(pulses), 32'd0);

        // ---- key (1,2) -> 6; sampled on col 2 at edge 12, strobe after edge 20
        pressed[1][2] = 1'b1;
        tick(8);  check("k6_col", 32'(cols_out), 32'hB);
        tick(11); check("k6_pre_vld", 32'(cmd_valid), 32'h0);
        tick(1);  check("k6_vld", 32'(cmd_valid), 32'h1);
        check("k6_cmd", 32'(cmd), 32'h6);
        check("k6_held", 32'(key_held), 32'h1);
        tick(1);  check_idle_out("k6_post");
        check("k6_held2", 32'(key_held), 32'h1);
        tick(19); check("k6_frozen", 32'(cols_out), 32'hB);
        pressed = '0;
        tick(9);  check("k6_rel_held", 32'(key_held), 32'h1);
        tick(1);  check("k6_rel_done", 32'(key_held), 32'h0);
        check("k6_next_col", 32'(cols_out), 32'h7);
        check("k6_pulses", 32'(pulses), 32'd1);

        // ---- bounce: (0,1) low for 5 cycles on col 1
        pressed[0][1] = 1'b1;
        tick(13); check("bnc_frozen", 32'(cols_out), 32'hD);
        pressed = '0;
        tick(3);  check("bnc_resume", 32'(cols_out), 32'hB);
        check("bnc_held", 32'(key_held), 32'h0);
        check("bnc_pulses", 32'(pulses), 32'd1);

        // ---- rows 0 and 2 on col 3 -> lowest row wins, code 3
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        tick(15); check("k3_pre_vld", 32'(cmd_valid), 32'h0);
        tick(1);  check("k3_vld", 32'(cmd_valid), 32'h1);
        check("k3_cmd", 32'(cmd), 32'h3);
        tick(4);  pressed = '0;
        tick(9);  check("k3_rel_held", 32'(key_held), 32'h1);
        tick(1);  check("k3_rel_done", 32'(key_held), 32'h0);
        check("k3_next_col", 32'(cols_out), 32'hE);
        check("k3_pulses", 32'(pulses), 32'd2);

        // ---- unmapped (3,3), then (0,0) pressed during its hold
        pressed[3][3] = 1'b1;
        tick(24); check("kF_held", 32'(key_held), 32'h1);
        check_idle_out("kF_emit");
        tick(2);  pressed[0][0] = 1'b1;
        tick(4);  check("kF_frozen", 32'(cols_out), 32'h7);
        pressed[3][3] = 1'b0;
        tick(10); check("kF_rel", 32'(key_held), 32'h0);
        check("kF_next_col", 32'(cols_out), 32'hE);
        check("kF_pulses", 32'(pulses), 32'd2);
        tick(11); check("k0_pre_vld", 32'(cmd_valid), 32'h0);
        tick(1);  check("k0_vld", 32'(cmd_valid), 32'h1);
        check("k0_cmd", 32'(cmd), 32'h0);
        tick(1);  pressed = '0;
        tick(10); check("k0_rel", 32'(key_held), 32'h0);
        check("k0_next_col", 32'(cols_out), 32'hD);
        check("k0_pulses", 32'(pulses), 32'd3);

        // ---- key (1,1) -> 5, reset during hold, re-detect after reset
        pressed[1][1] = 1'b1;
        tick(12); check("k5_vld", 32'(cmd_valid), 32'h1);
        check("k5_cmd", 32'(cmd), 32'h5);
        tick(8);  check("k5_held", 32'(key_held), 32'h1);
        reset = 1'b1;
        #1;
        check("k5_rst_cols", 32'(cols_out), 32'hE);
        check("k5_rst_held", 32'(key_held), 32'h0);
        check_idle_out("k5_rst");
        tick(2);
        reset = 1'b0;
        tick(15); check("k5b_pre_vld", 32'(cmd_valid), 32'h0);
        tick(1);  check("k5b_vld", 32'(cmd_valid), 32'h1);
        check("k5b_cmd", 32'(cmd), 32'h5);
`ifdef KEYPAD_REPEAT_EN
        tick(19); check("rep_pre", 32'(cmd_valid), 32'h0);
        tick(1);  check("rep20_vld", 32'(cmd_valid), 32'h1);
        check("rep20_cmd", 32'(cmd), 32'h5);
        tick(10); check("rep30_vld", 32'(cmd_valid), 32'h1);
        tick(10); check("rep40_vld", 32'(cmd_valid), 32'h1);
        tick(10); check("rep50_vld", 32'(cmd_valid), 32'h1);
        check("rep50_cmd", 32'(cmd), 32'h5);
        tick(4);  pressed = '0;
`else
        tick(20); check("norep_vld", 32'(cmd_valid), 32'h0);
        tick(34); pressed = '0;
`endif
        tick(9);  check("k5b_rel_held", 32'(key_held), 32'h1);
        tick(1);  check("k5b_rel", 32'(key_held), 32'h0);
        check("k5b_next_col", 32'(cols_out), 32'hB);
`ifdef KEYPAD_REPEAT_EN
        check("k5b_pulses", 32'(pulses), 32'd9);
`else
        check("k5b_pulses", 32'(pulses), 32'd5);
`endif

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
